sram_avalon_ctrl: RTL

- Avalon-MM slave that converts single-word read/write transfers into timed cycles on the 16-bit asynchronous SRAM.
- Sits between the system interconnect and the `sram_*` conduit that the board top level routes to the SRAM pins.
- All SRAM pin outputs are registered; reads return through `avs_readdatavalid` with fixed latency.

---
 rtl/sram_avalon_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_avalon_ctrl.sv
// sram_avalon_ctrl: Avalon-MM slave bridging single-word read/write transfers
// onto a 16-bit asynchronous SRAM. All SRAM pin outputs are registered, and
// read data returns through avs_readdatavalid with a fixed latency.
//
// Optional feature macro: SRAM_INPUT_REG_EN
//   When defined, sram_dq is first captured into an input register on the
//   last RD edge and copied to avs_readdata one edge later (RD_CAP state).
//   This adds one cycle of read latency and lets the capture flop sit in
//   the I/O cell.
module sram_avalon_ctrl #(
    parameter int AW         = 18,
    parameter int DW         = 16,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DW-1:0]     avs_writedata,
    input  logic [DW/8-1:0]   avs_byteenable,
    output logic              avs_waitrequest,
    output logic [DW-1:0]     avs_readdata,
    output logic              avs_readdatavalid,
    output logic [AW-1:0]     sram_addr,
    inout  wire  [DW-1:0]     sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DW/8-1:0]   sram_be_n
);

    localparam int BW   = DW / 8;
    localparam int MAXW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CW   = (MAXW < 1) ? 1 : $clog2(MAXW + 1);

    localparam logic [CW-1:0] RD_LAST = CW'(READ_WAIT);
    localparam logic [CW-1:0] WR_LAST = CW'(WRITE_WAIT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_WR      = 3'd2;
    localparam logic [2:0] S_WR_HOLD = 3'd3;
`ifdef SRAM_INPUT_REG_EN
    localparam logic [2:0] S_RD_CAP  = 3'd4;
`endif

    // Controller state and latched request
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [BW-1:0] ben_q,   ben_d;

    // Registered SRAM pins
    logic          ce_n_q,  ce_n_d;
    logic          oe_n_q,  oe_n_d;
    logic          we_n_q,  we_n_d;
    logic [BW-1:0] be_n_q,  be_n_d;
    logic          dq_oe_q, dq_oe_d;

    // Avalon read return
    logic [DW-1:0] rdata_q,  rdata_d;
    logic          rvalid_q, rvalid_d;

`ifdef SRAM_INPUT_REG_EN
    logic [DW-1:0] cap_q, cap_d;
`endif

    // Next-state, request latching and read-data capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ben_d    = ben_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
`ifdef SRAM_INPUT_REG_EN
        cap_d    = cap_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (avs_write || avs_read) begin
                    addr_d  = avs_address;
                    wdata_d = avs_writedata;
                    ben_d   = avs_byteenable;
                    cnt_d   = '0;
                    // Write wins when both are requested together
                    state_d = avs_write ? S_WR : S_RD;
                end
            end

            S_RD: begin
                if (cnt_q == RD_LAST) begin
`ifdef SRAM_INPUT_REG_EN
                    cap_d    = sram_dq;
                    state_d  = S_RD_CAP;
`else
                    rdata_d  = sram_dq;
                    rvalid_d = 1'b1;
                    state_d  = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef SRAM_INPUT_REG_EN
            S_RD_CAP: begin
                rdata_d  = cap_q;
                rvalid_d = 1'b1;
                state_d  = S_IDLE;
            end
`endif

            S_WR: begin
                if (cnt_q == WR_LAST) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WR_HOLD: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin values are decoded from the next state so every pin is a flop
    // whose value belongs to the state being entered on this edge.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        dq_oe_d = 1'b0;

        case (state_d)
            S_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end

            S_WR: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~ben_d;
                dq_oe_d = 1'b1;
            end

            S_WR_HOLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~ben_d;
                dq_oe_d = 1'b1;
            end

            default: begin
                ce_n_d  = 1'b1;
            end
        endcase
    end

    // State, request and pin registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ben_q    <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            be_n_q   <= '1;
            dq_oe_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef SRAM_INPUT_REG_EN
            cap_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ben_q    <= ben_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            be_n_q   <= be_n_d;
            dq_oe_q  <= dq_oe_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef SRAM_INPUT_REG_EN
            cap_q    <= cap_d;
`endif
        end
    end

    // Stall whenever busy or held in reset
    assign avs_waitrequest   = (state_q != S_IDLE) || !rst_n;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_be_n = be_n_q;
    assign sram_dq   = dq_oe_q ? wdata_q : {DW{1'bz}};

endmodule
